// File: rtl/tex_column_walker.sv
// Column pixel sequencer: expands one DDA ray result into SCREEN_HEIGHT framebuffer writes (ceiling/wall/floor).
// Latency: 16-cycle divide (skipped when no wall) + 1 setup cycle, then 1 row/cycle, or one request/response round trip per textured row.
// Backpressure: col_ready_out is high only in IDLE. Texture fetches wait for tex_valid_in up to TEX_TIMEOUT cycles. The framebuffer port is write-only and never stalls.
//
// Ports:
//   pixel_clk_in / rst_n_in      clock, asynchronous active-low reset
//   col_*                        column descriptor valid/ready handshake (hcount, line height, wallX, map cell)
//   tex_req_out / tex_*_out      one-cycle texel request plus the coordinates held for its duration
//   tex_pixel_in / tex_valid_in  texel response
//   fb_we_out / fb_addr_out / fb_data_out  registered framebuffer write port
//   col_done_out                 pulses with the final write of a column
//   tex_timeout_out              sticky flag, set by any abandoned fetch
module tex_column_walker #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEIL_COLOR    = 16'h4208,
    parameter logic [15:0] FLOOR_COLOR   = 16'h8410,
    parameter logic [15:0] FLAT_COLOR    = 16'hF800,
    parameter int          TEX_TIMEOUT   = 7
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        col_valid_in,
    output logic        col_ready_out,
    input  logic [8:0]  col_hcount_in,
    input  logic [15:0] col_line_height_in,
    input  logic [15:0] col_wallX_in,
    input  logic [3:0]  col_map_in,
    output logic        tex_req_out,
    output logic [15:0] tex_wallX_out,
    output logic [7:0]  tex_vcount_out,
    output logic [3:0]  tex_id_out,
    input  logic [15:0] tex_pixel_in,
    input  logic        tex_valid_in,
    output logic        fb_we_out,
    output logic [15:0] fb_addr_out,
    output logic [15:0] fb_data_out,
    output logic        col_done_out,
    output logic        tex_timeout_out
);

    localparam logic [7:0]  H_LAST    = 8'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]  H_HALF    = 8'(SCREEN_HEIGHT / 2);
    localparam logic [15:0] DIVIDEND  = 16'(SCREEN_HEIGHT * 256);
    localparam logic [15:0] ROW_STEP  = 16'(SCREEN_WIDTH);
    localparam logic [3:0]  WAIT_LAST = 4'(TEX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_SETUP, S_PIXEL, S_WAIT, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched descriptor
    logic [8:0]  hcount_q;
    logic [15:0] lh_q;
    logic [15:0] wallx_q;
    logic [3:0]  map_q;

    // Divider: the dividend shifts out of quo_q MSB-first while quotient
    // bits shift in, so after 16 iterations quo_q holds the Q8.8 step.
    logic [15:0] quo_q;
    logic [15:0] rem_q;
    logic [3:0]  div_cnt_q;

    logic [7:0]  draw_start_q, draw_end_q;
    logic [7:0]  row_q;
    logic [15:0] addr_q;      // row_q*SCREEN_WIDTH + hcount, kept incrementally
    logic [23:0] tex_pos_q;
    logic [7:0]  vcount_q;
    logic [3:0]  wait_cnt_q;

    logic        tex_req_q, fb_we_q, done_q, timeout_q;
    logic [15:0] fb_addr_q, fb_data_q;

    // Divider datapath
    logic [16:0] rem_shift;
    logic [15:0] rem_diff;
    logic        div_bit;

    always_comb begin
        rem_shift = {rem_q, quo_q[15]};
        rem_diff  = rem_shift[15:0] - lh_q;
        div_bit   = (rem_shift >= {1'b0, lh_q});
    end

    // Setup datapath: wall span and initial texture position
    logic [14:0] half, skip;
    logic [15:0] end_sum;
    logic [7:0]  start_calc, end_calc;
    logic [23:0] pos_init;

    always_comb begin
        half       = lh_q[15:1];
        start_calc = (half > {7'd0, H_HALF}) ? 8'd0 : (H_HALF - half[7:0]);
        end_sum    = {8'd0, H_HALF} + {1'b0, half} - 16'd1;
        end_calc   = (end_sum > {8'd0, H_LAST}) ? H_LAST : end_sum[7:0];
        // Rows of a wall taller than the screen that fall above row 0
        skip       = (half > {7'd0, H_HALF}) ? (half - {7'd0, H_HALF}) : 15'd0;
        pos_init   = {9'd0, skip} * {8'd0, quo_q};
    end

    // Row classification
    logic       is_ceil, is_floor, textured, last_row, wait_expired;
    logic [7:0] vcount_calc;

    always_comb begin
        is_ceil      = (row_q < draw_start_q);
        is_floor     = (row_q > draw_end_q);
        textured     = (map_q >= 4'd3) && (map_q <= 4'd5);
        last_row     = (row_q == H_LAST);
        wait_expired = (wait_cnt_q == WAIT_LAST);
        vcount_calc  = (tex_pos_q[15:8] > H_LAST) ? H_LAST : tex_pos_q[15:8];
    end

    // State register
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (col_valid_in)
                         state_d = (col_line_height_in != 16'd0) ? S_DIV : S_SETUP;
            S_DIV:   if (div_cnt_q == 4'd15) state_d = S_SETUP;
            S_SETUP: state_d = S_PIXEL;
            S_PIXEL: if (!is_ceil && !is_floor && textured) state_d = S_WAIT;
                     else if (last_row)                     state_d = S_DONE;
            S_WAIT:  if (tex_valid_in || wait_expired)
                         state_d = last_row ? S_DONE : S_PIXEL;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-cycle actions
    logic        accept, wr_en, row_adv, pos_adv, req, to_hit;
    logic [15:0] wr_data;

    always_comb begin
        accept  = (state_q == S_IDLE) && col_valid_in;
        wr_en   = 1'b0;
        wr_data = 16'd0;
        row_adv = 1'b0;
        pos_adv = 1'b0;
        req     = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            S_PIXEL: begin
                if (is_ceil) begin
                    wr_en = 1'b1; wr_data = CEIL_COLOR; row_adv = 1'b1;
                end else if (is_floor) begin
                    wr_en = 1'b1; wr_data = FLOOR_COLOR; row_adv = 1'b1;
                end else if (textured) begin
                    req = 1'b1;
                end else begin
                    wr_en = 1'b1; wr_data = FLAT_COLOR; row_adv = 1'b1; pos_adv = 1'b1;
                end
            end
            S_WAIT: begin
                if (tex_valid_in) begin
                    wr_en = 1'b1; wr_data = tex_pixel_in; row_adv = 1'b1; pos_adv = 1'b1;
                end else if (wait_expired) begin
                    wr_en = 1'b1; wr_data = FLAT_COLOR; row_adv = 1'b1; to_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_q     <= '0;
            lh_q         <= '0;
            wallx_q      <= '0;
            map_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            div_cnt_q    <= '0;
            draw_start_q <= '0;
            draw_end_q   <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            tex_pos_q    <= '0;
            vcount_q     <= '0;
            wait_cnt_q   <= '0;
            tex_req_q    <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            if (accept) begin
                hcount_q  <= col_hcount_in;
                lh_q      <= col_line_height_in;
                wallx_q   <= col_wallX_in;
                map_q     <= col_map_in;
                quo_q     <= (col_line_height_in != 16'd0) ? DIVIDEND : 16'd0;
                rem_q     <= '0;
                div_cnt_q <= '0;
            end
            if (state_q == S_DIV) begin
                rem_q     <= div_bit ? rem_diff : rem_shift[15:0];
                quo_q     <= {quo_q[14:0], div_bit};
                div_cnt_q <= div_cnt_q + 4'd1;
            end
            if (state_q == S_SETUP) begin
                draw_start_q <= start_calc;
                draw_end_q   <= end_calc;
                tex_pos_q    <= pos_init;
                row_q        <= '0;
                addr_q       <= {7'd0, hcount_q};
            end
            if (row_adv) begin
                row_q  <= row_q + 8'd1;
                addr_q <= addr_q + ROW_STEP;
            end
            if (pos_adv) tex_pos_q <= tex_pos_q + {8'd0, quo_q};
            if (req) begin
                vcount_q   <= vcount_calc;
                wait_cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
            tex_req_q <= req;
            fb_we_q   <= wr_en;
            if (wr_en) begin
                fb_addr_q <= addr_q;
                fb_data_q <= wr_data;
            end
            done_q <= row_adv && last_row;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign col_ready_out   = (state_q == S_IDLE);
    assign tex_req_out     = tex_req_q;
    assign tex_wallX_out   = wallx_q;
    assign tex_vcount_out  = vcount_q;
    assign tex_id_out      = map_q;
    assign fb_we_out       = fb_we_q;
    assign fb_addr_out     = fb_addr_q;
    assign fb_data_out     = fb_data_q;
    assign col_done_out    = done_q;
    assign tex_timeout_out = timeout_q;

endmodule

// File: tb/tb_tex_column_walker.sv
// Directed bench for tex_column_walker: reset, no-wall, flat wall, textured, timeout, back-to-back and mid-column reset.
module tb_tex_column_walker;
    logic        pixel_clk_in, rst_n_in, col_valid_in, col_ready_out;
    logic [8:0]  col_hcount_in;
    logic [15:0] col_line_height_in, col_wallX_in;
    logic [3:0]  col_map_in;
    logic        tex_req_out;
    logic [15:0] tex_wallX_out;
    logic [7:0]  tex_vcount_out;
    logic [3:0]  tex_id_out;
    logic [15:0] tex_pixel_in;
    logic        tex_valid_in;
    logic        fb_we_out;
    logic [15:0] fb_addr_out, fb_data_out;
    logic        col_done_out, tex_timeout_out;

    localparam logic [15:0] CEIL  = 16'h4208;
    localparam logic [15:0] FLOOR = 16'h8410;
    localparam logic [15:0] FLAT  = 16'hF800;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tex_lat = 2;
    int pend = 0;
    int done_cnt = 0;
    logic done_we = 1'b0;
    logic [15:0] wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];
    logic [7:0]  rq_v[$];
    int          rq_cyc[$];

    tex_column_walker dut (
        .pixel_clk_in(pixel_clk_in), .rst_n_in(rst_n_in),
        .col_valid_in(col_valid_in), .col_ready_out(col_ready_out),
        .col_hcount_in(col_hcount_in), .col_line_height_in(col_line_height_in),
        .col_wallX_in(col_wallX_in), .col_map_in(col_map_in),
        .tex_req_out(tex_req_out), .tex_wallX_out(tex_wallX_out),
        .tex_vcount_out(tex_vcount_out), .tex_id_out(tex_id_out),
        .tex_pixel_in(tex_pixel_in), .tex_valid_in(tex_valid_in),
        .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
        .col_done_out(col_done_out), .tex_timeout_out(tex_timeout_out)
    );

    initial begin
        pixel_clk_in = 1'b0;
        forever #5 pixel_clk_in = ~pixel_clk_in;
    end

    always @(posedge pixel_clk_in) cyc <= cyc + 1;

    function automatic logic [15:0] texel(input logic [7:0] v);
        return {v, v ^ 8'h5A};
    endfunction

    // Texture stage: answers a request tex_lat cycles after it is seen; tex_lat=0 never answers
    initial begin
        tex_valid_in = 1'b0;
        tex_pixel_in = 16'd0;
        forever begin
            @(posedge pixel_clk_in);
            #1;
            tex_valid_in = 1'b0;
            tex_pixel_in = 16'd0;
            if (!rst_n_in) pend = 0;
            else begin
                if (pend > 0) begin
                    pend = pend - 1;
                    if (pend == 0) begin
                        tex_valid_in = 1'b1;
                        tex_pixel_in = texel(tex_vcount_out);
                    end
                end
                if (tex_req_out && tex_lat > 0) pend = tex_lat;
            end
        end
    end

    // Log of writes, requests and done pulses
    initial begin
        forever begin
            @(posedge pixel_clk_in);
            #1;
            if (fb_we_out) begin
                wq_addr.push_back(fb_addr_out);
                wq_data.push_back(fb_data_out);
                wq_cyc.push_back(cyc);
            end
            if (tex_req_out) begin
                rq_v.push_back(tex_vcount_out);
                rq_cyc.push_back(cyc);
            end
            if (col_done_out) begin
                done_cnt = done_cnt + 1;
                done_we  = fb_we_out;
            end
        end
    end

    task automatic tick;
        @(posedge pixel_clk_in);
        #2;
    endtask

    task automatic clear_logs;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        rq_v.delete(); rq_cyc.delete();
        done_cnt = 0;
        done_we  = 1'b0;
    endtask

    // acc = index of the cycle in which valid && ready was present
    task automatic send_col(input logic [8:0] hc, input logic [15:0] lh, input logic [15:0] wx,
                            input logic [3:0] mp, output int acc);
        col_hcount_in = hc; col_line_height_in = lh; col_wallX_in = wx; col_map_in = mp;
        col_valid_in = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (col_ready_out) begin
                acc = cyc;
                break;
            end
            tick;
        end
        tick;
        col_valid_in = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (col_done_out) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (col_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", col_ready_out); end
        total++; if (fb_we_out !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", fb_we_out); end
        total++; if (fb_addr_out !== 16'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", fb_addr_out); end
        total++; if (fb_data_out !== 16'd0) begin bad++; $display("FAIL reset_data got %h want 0", fb_data_out); end
        total++; if (tex_req_out !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", tex_req_out); end
        total++; if (tex_vcount_out !== 8'd0) begin bad++; $display("FAIL reset_vcount got %0d want 0", tex_vcount_out); end
        total++; if (col_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", col_done_out); end
        total++; if (tex_timeout_out !== 1'b0) begin bad++; $display("FAIL reset_timeout got %b want 0", tex_timeout_out); end
        rst_n_in = 1'b1;
        tick;
    endtask

    task automatic test_no_wall;
        int acc, dc;
        logic [15:0] exp_a, exp_d;
        clear_logs;
        send_col(9'd7, 16'd0, 16'd0, 4'd0, acc);
        total++; if (col_ready_out !== 1'b0) begin bad++; $display("FAIL nowall_busy ready=%b want 0", col_ready_out); end
        wait_done(dc);
        total++; if (dc - acc != 182) begin bad++; $display("FAIL nowall_latency got %0d want 182", dc - acc); end
        total++; if (wq_addr.size() != 180) begin bad++; $display("FAIL nowall_count got %0d want 180", wq_addr.size()); end
        for (int r = 0; r < 180 && r < wq_addr.size(); r++) begin
            exp_a = 16'(r * 320 + 7);
            exp_d = (r < 90) ? CEIL : FLOOR;
            total++; if (wq_addr[r] !== exp_a) begin bad++; $display("FAIL nowall_addr row %0d got %0d want %0d", r, wq_addr[r], exp_a); end
            total++; if (wq_data[r] !== exp_d) begin bad++; $display("FAIL nowall_data row %0d got %h want %h", r, wq_data[r], exp_d); end
        end
        total++; if (rq_v.size() != 0) begin bad++; $display("FAIL nowall_req got %0d want 0", rq_v.size()); end
        total++; if (done_we !== 1'b1) begin bad++; $display("FAIL nowall_done_we got %b want 1", done_we); end
        total++; if (wq_cyc.size() == 0 || wq_cyc[wq_cyc.size()-1] != dc) begin
            bad++; $display("FAIL nowall_last_write_cycle done=%0d writes=%0d", dc, wq_cyc.size()); end
    endtask

    task automatic test_flat_wall;
        int acc, dc;
        logic [15:0] exp_d;
        clear_logs;
        send_col(9'd0, 16'd90, 16'd0, 4'd1, acc);
        wait_done(dc);
        total++; if (dc - acc != 198) begin bad++; $display("FAIL flat_latency got %0d want 198", dc - acc); end
        total++; if (wq_addr.size() != 180) begin bad++; $display("FAIL flat_count got %0d want 180", wq_addr.size()); end
        for (int r = 0; r < 180 && r < wq_addr.size(); r++) begin
            exp_d = (r < 45) ? CEIL : (r <= 134) ? FLAT : FLOOR;
            total++; if (wq_addr[r] !== 16'(r * 320)) begin bad++; $display("FAIL flat_addr row %0d got %0d want %0d", r, wq_addr[r], r * 320); end
            total++; if (wq_data[r] !== exp_d) begin bad++; $display("FAIL flat_data row %0d got %h want %h", r, wq_data[r], exp_d); end
        end
        total++; if (rq_v.size() != 0) begin bad++; $display("FAIL flat_req got %0d want 0", rq_v.size()); end
    endtask

    task automatic test_textured;
        int acc, dc;
        logic [7:0] vexp;
        tex_lat = 2;
        clear_logs;
        send_col(9'd5, 16'd360, 16'h1234, 4'd3, acc);
        wait_done(dc);
        total++; if (dc - acc != 738) begin bad++; $display("FAIL tex_latency got %0d want 738", dc - acc); end
        total++; if (rq_v.size() != 180) begin bad++; $display("FAIL tex_req_count got %0d want 180", rq_v.size()); end
        total++; if (wq_addr.size() != 180) begin bad++; $display("FAIL tex_count got %0d want 180", wq_addr.size()); end
        for (int r = 0; r < 180 && r < wq_addr.size() && r < rq_v.size(); r++) begin
            vexp = 8'(45 + (r >> 1));
            total++; if (rq_v[r] !== vexp) begin bad++; $display("FAIL tex_vcount row %0d got %0d want %0d", r, rq_v[r], vexp); end
            total++; if (wq_data[r] !== texel(vexp)) begin bad++; $display("FAIL tex_data row %0d got %h want %h", r, wq_data[r], texel(vexp)); end
            total++; if (wq_addr[r] !== 16'(r * 320 + 5)) begin bad++; $display("FAIL tex_addr row %0d got %0d want %0d", r, wq_addr[r], r * 320 + 5); end
            if (r > 0) begin
                total++; if (rq_cyc[r] - rq_cyc[r-1] < 3) begin bad++; $display("FAIL tex_req_gap row %0d got %0d want >=3", r, rq_cyc[r] - rq_cyc[r-1]); end
            end
        end
        total++; if (tex_wallX_out !== 16'h1234) begin bad++; $display("FAIL tex_wallx got %h want 1234", tex_wallX_out); end
        total++; if (tex_id_out !== 4'd3) begin bad++; $display("FAIL tex_id got %0d want 3", tex_id_out); end
        total++; if (tex_timeout_out !== 1'b0) begin bad++; $display("FAIL tex_no_timeout got %b want 0", tex_timeout_out); end
    endtask

    task automatic test_timeout;
        int acc, dc;
        tex_lat = 0;
        clear_logs;
        total++; if (tex_timeout_out !== 1'b0) begin bad++; $display("FAIL to_initial got %b want 0", tex_timeout_out); end
        send_col(9'd6, 16'd360, 16'h00FF, 4'd4, acc);
        wait_done(dc);
        total++; if (dc - acc != 1458) begin bad++; $display("FAIL to_latency got %0d want 1458", dc - acc); end
        total++; if (wq_addr.size() != 180) begin bad++; $display("FAIL to_count got %0d want 180", wq_addr.size()); end
        for (int r = 0; r < 180 && r < wq_data.size(); r++) begin
            total++; if (wq_data[r] !== FLAT) begin bad++; $display("FAIL to_data row %0d got %h want %h", r, wq_data[r], FLAT); end
        end
        total++; if (wq_cyc.size() == 0 || rq_cyc.size() == 0 || wq_cyc[0] - rq_cyc[0] != 7) begin
            bad++; $display("FAIL to_wait_cycles writes=%0d reqs=%0d want gap 7", wq_cyc.size(), rq_cyc.size()); end
        total++; if (tex_timeout_out !== 1'b1) begin bad++; $display("FAIL to_flag got %b want 1", tex_timeout_out); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL to_done got %0d want 1", done_cnt); end
        tex_lat = 2;
    endtask

    task automatic test_back_to_back;
        int acc_a, acc_b, done_a, done_b;
        clear_logs;
        acc_a = -1; acc_b = -1; done_a = -1;
        col_hcount_in = 9'd10; col_line_height_in = 16'd0; col_wallX_in = 16'd0; col_map_in = 4'd0;
        col_valid_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (col_ready_out) begin acc_a = cyc; break; end
            tick;
        end
        tick;
        col_hcount_in = 9'd11; col_line_height_in = 16'd90; col_map_in = 4'd2;
        total++; if (col_ready_out !== 1'b0) begin bad++; $display("FAIL b2b_busy ready=%b want 0", col_ready_out); end
        for (int i = 0; i < 400; i++) begin
            tick;
            if (col_done_out) done_a = cyc;
            if (col_ready_out) begin acc_b = cyc; break; end
        end
        tick;
        col_valid_in = 1'b0;
        wait_done(done_b);
        total++; if (done_a - acc_a != 182) begin bad++; $display("FAIL b2b_first_latency got %0d want 182", done_a - acc_a); end
        total++; if (acc_b != done_a + 1) begin bad++; $display("FAIL b2b_second_accept got %0d want %0d", acc_b, done_a + 1); end
        total++; if (done_b - acc_b != 198) begin bad++; $display("FAIL b2b_second_latency got %0d want 198", done_b - acc_b); end
        total++; if (wq_addr.size() != 360) begin bad++; $display("FAIL b2b_count got %0d want 360", wq_addr.size()); end
        if (wq_addr.size() == 360) begin
            total++; if (wq_addr[179] !== 16'(179 * 320 + 10)) begin bad++; $display("FAIL b2b_a_last_addr got %0d want %0d", wq_addr[179], 179 * 320 + 10); end
            total++; if (wq_addr[180] !== 16'd11) begin bad++; $display("FAIL b2b_b_first_addr got %0d want 11", wq_addr[180]); end
            total++; if (wq_cyc[180] <= done_a) begin bad++; $display("FAIL b2b_overlap got %0d want >%0d", wq_cyc[180], done_a); end
            total++; if (wq_data[225] !== FLAT) begin bad++; $display("FAIL b2b_b_wall got %h want %h", wq_data[225], FLAT); end
        end
        total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int acc, dc;
        logic [15:0] exp_d;
        tex_lat = 2;
        clear_logs;
        send_col(9'd2, 16'd360, 16'h7777, 4'd5, acc);
        for (int i = 0; i < 2000; i++) begin
            if (rq_cyc.size() >= 61) break;
            tick;
        end
        total++; if (wq_addr.size() != 60) begin bad++; $display("FAIL rmid_rows_before got %0d want 60", wq_addr.size()); end
        rst_n_in = 1'b0;
        #1;
        total++; if (col_ready_out !== 1'b1) begin bad++; $display("FAIL rmid_ready got %b want 1", col_ready_out); end
        total++; if (tex_req_out !== 1'b0) begin bad++; $display("FAIL rmid_req got %b want 0", tex_req_out); end
        total++; if (fb_we_out !== 1'b0) begin bad++; $display("FAIL rmid_we got %b want 0", fb_we_out); end
        total++; if (fb_addr_out !== 16'd0) begin bad++; $display("FAIL rmid_addr got %0d want 0", fb_addr_out); end
        total++; if (tex_vcount_out !== 8'd0) begin bad++; $display("FAIL rmid_vcount got %0d want 0", tex_vcount_out); end
        total++; if (tex_wallX_out !== 16'd0) begin bad++; $display("FAIL rmid_wallx got %h want 0", tex_wallX_out); end
        total++; if (tex_id_out !== 4'd0) begin bad++; $display("FAIL rmid_id got %0d want 0", tex_id_out); end
        total++; if (tex_timeout_out !== 1'b0) begin bad++; $display("FAIL rmid_timeout got %b want 0", tex_timeout_out); end
        clear_logs;
        tick; tick; tick;
        rst_n_in = 1'b1;
        tick; tick; tick;
        total++; if (wq_addr.size() != 0 || rq_v.size() != 0) begin
            bad++; $display("FAIL rmid_quiet writes=%0d reqs=%0d want 0", wq_addr.size(), rq_v.size()); end
        send_col(9'd3, 16'd90, 16'd0, 4'd1, acc);
        wait_done(dc);
        total++; if (dc - acc != 198) begin bad++; $display("FAIL rmid_latency got %0d want 198", dc - acc); end
        total++; if (wq_addr.size() != 180) begin bad++; $display("FAIL rmid_count got %0d want 180", wq_addr.size()); end
        for (int r = 0; r < 180 && r < wq_addr.size(); r++) begin
            exp_d = (r < 45) ? CEIL : (r <= 134) ? FLAT : FLOOR;
            total++; if (wq_addr[r] !== 16'(r * 320 + 3)) begin bad++; $display("FAIL rmid_addr row %0d got %0d want %0d", r, wq_addr[r], r * 320 + 3); end
            total++; if (wq_data[r] !== exp_d) begin bad++; $display("FAIL rmid_data row %0d got %h want %h", r, wq_data[r], exp_d); end
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        col_valid_in = 1'b0;
        col_hcount_in = 9'd0;
        col_line_height_in = 16'd0;
        col_wallX_in = 16'd0;
        col_map_in = 4'd0;
        test_reset;
        test_no_wall;
        test_flat_wall;
        test_textured;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tex_column_walker.md
Name: tex_column_walker

Overview:
- Per-column pixel sequencer between the DDA ray stage and the texture lookup stage.
- Accepts one ray result per screen column: column index, projected wall height, wall hit fraction and map cell value.
- Walks rows 0..SCREEN_HEIGHT-1. Each row becomes a ceiling, floor, flat-wall or textured-wall pixel.
- Textured pixels are fetched through the texture stage's request/valid interface. Every pixel is written to the framebuffer write port.

Parameters:
- SCREEN_WIDTH, 320, columns per frame; used for framebuffer addressing.
- SCREEN_HEIGHT, 180, rows per column; also the texture row range.
- CEIL_COLOR, 16'h4208, RGB565 ceiling colour.
- FLOOR_COLOR, 16'h8410, RGB565 floor colour.
- FLAT_COLOR, 16'hF800, RGB565 colour for non-textured walls and for timed-out texture fetches.
- TEX_TIMEOUT, 7, maximum TEX_WAIT cycles before a fetch is abandoned.

Ports:
- pixel_clk_in  in  1  pixel clock; all logic on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- col_valid_in  in  1  column descriptor valid.
- col_ready_out  out  1  block can accept a descriptor.
- col_hcount_in  in  9  column index, 0..SCREEN_WIDTH-1.
- col_line_height_in  in  16  projected wall height in pixels, unsigned; 0 means no wall.
- col_wallX_in  in  16  wall hit fraction; bits [7:0] used downstream.
- col_map_in  in  4  map cell value; 3..5 are textured.
- tex_req_out  out  1  one-cycle texture request pulse.
- tex_wallX_out  out  16  latched wallX.
- tex_vcount_out  out  8  texture row, 0..SCREEN_HEIGHT-1.
- tex_id_out  out  4  latched map value.
- tex_pixel_in  in  16  texel from texture stage.
- tex_valid_in  in  1  texel valid.
- fb_we_out  out  1  framebuffer write strobe.
- fb_addr_out  out  16  row*SCREEN_WIDTH + hcount.
- fb_data_out  out  16  RGB565 pixel.
- col_done_out  out  1  one-cycle pulse after the last row of a column is written.
- tex_timeout_out  out  1  sticky flag, set on any abandoned fetch; cleared only by reset.

Behaviour:
- Reset (asynchronous, any state, including mid-column):
  - State goes to IDLE.
  - All outputs are 0, except col_ready_out=1.
  - The descriptor in flight is discarded. No partial writes follow reset release.
- Descriptor handshake:
  - col_ready_out=1 only in IDLE.
  - A descriptor is accepted on a cycle with col_valid_in && col_ready_out; all fields are latched.
- IDLE -> DIV if line height != 0; otherwise -> SETUP with step=0.
- DIV (exactly 16 cycles, restoring divider):
  - step = floor((SCREEN_HEIGHT<<8)/line_height), unsigned Q8.8, 16 bits.
  - Then -> SETUP.
- SETUP (1 cycle):
  - half = lh>>1.
  - Signed draw_start = H/2 - half, clamped to >= 0.
  - Signed draw_end = H/2 + half - 1, clamped to <= H-1.
  - tex_pos (Q8.8, 24 bits) = max(0, half - H/2) * step.
  - row = 0. Then -> PIXEL.
- PIXEL (one row per cycle unless textured):
  - row < draw_start, or lh=0 and row < H/2: write CEIL_COLOR.
  - row > draw_end, or lh=0 and row >= H/2: write FLOOR_COLOR.
  - Wall row, map not in 3..5: write FLAT_COLOR; tex_pos += step.
  - Wall row, map in 3..5: pulse tex_req_out for 1 cycle with tex_vcount_out = min(tex_pos[15:8], H-1); no write this cycle; -> TEX_WAIT.
- TEX_WAIT:
  - tex_wallX_out, tex_vcount_out and tex_id_out are held stable.
  - tex_req_out stays low, which guarantees at least one low cycle between request pulses.
  - On tex_valid_in: write tex_pixel_in; tex_pos += step; row++; -> PIXEL.
  - After TEX_TIMEOUT cycles without tex_valid_in: write FLAT_COLOR; set tex_timeout_out; advance row; -> PIXEL.
  - tex_valid_in outside TEX_WAIT is ignored.
- Framebuffer writes:
  - fb_we_out, fb_addr_out and fb_data_out are registered and appear 1 cycle after the deciding cycle.
  - Exactly SCREEN_HEIGHT writes per column, rows in ascending order.
- Last row: after the row H-1 write -> DONE. col_done_out is pulsed 1 cycle, coincident with the final fb_we_out; then -> IDLE.
- Arithmetic: tex_pos does not wrap within a column (max 23-bit). fb_addr max 57599 fits 16 bits.

Test Plan:
- lh=0, hcount=7 -> 90 CEIL writes at addrs 7, 327, ...; then 90 FLOOR writes; no tex_req; done pulse with the 180th write; total 182 cycles accept-to-done.
- lh=90, map=1, hcount=0 -> step=512; rows 0-44 CEIL, 45-134 FLAT, 135-179 FLOOR; no tex_req.
- lh=360, map=3, texture model with 2-cycle latency -> step=128, tex_pos init 11520; 180 req pulses; tex_vcount 45 at row 0, 134 at row 179; all writes carry model texels; req pulses separated by >=2 low cycles.
- map=4 with a texture model that never asserts valid -> each row written FLAT after 7 wait cycles; tex_timeout_out=1; done still asserted.
- Back-to-back descriptors: col_valid_in held high -> col_ready_out low from accept to done; second column accepted in the cycle after done; no overlap of writes.
- Assert rst_n_in mid-TEX_WAIT at row 60 -> outputs zero immediately, col_ready_out=1; after release, a new column runs cleanly from row 0.
